resp_demux: RTL and testbench
=============================

Name: resp_demux

Overview:
- 1-to-2 demultiplexing router with per-output buffering; the distribution counterpart to the pipeline's 2-1 select muxes.
- Takes one valid/ready response stream, e.g. shared memory responses, and steers each beat to output 0 (instruction fetch side) or output 1 (data side) by a per-beat select bit.
- Each output has its own small FIFO, so a stalled consumer never corrupts ordering on the other output.
- Sits between the unified memory port and the IF/MEM pipeline stages.

Parameters:
- WIDTH, 32, data width of every stream.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  input beat present.
- in_sel  input  1  destination of the beat: 0 selects out0, 1 selects out1.
- in_data  input  WIDTH  input payload.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- out0_valid  output  1  out0 head entry valid.
- out0_data  output  WIDTH  out0 head payload.
- out0_ready  input  1  out0 consumer accepts the head entry.
- out1_valid  output  1  out1 head entry valid.
- out1_data  output  WIDTH  out1 head payload.
- out1_ready  input  1  out1 consumer accepts the head entry.
- out0_count  output  $clog2(DEPTH)+1  out0 FIFO occupancy.
- out1_count  output  $clog2(DEPTH)+1  out1 FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - all pointers and counts go to 0.
  - storage is cleared to 0.
  - outN_valid = 0, outN_data = 0, outN_count = 0.
- Handshake: valid/ready. A transfer occurs on a rising clk edge where valid && ready.
- in_ready:
  - in_sel ? !full1 : !full0, combinational from in_sel and registered counts only.
  - It never depends on outN_ready, so there is no combinational ready path through the block.
  - in_ready with in_valid = 0 still reflects the FIFO chosen by the current in_sel.
- Push: on accept, in_data is written at wr_ptr of the selected FIFO, wr_ptr increments modulo DEPTH, and count increments.
- Pop: when outN_valid && outN_ready, rd_ptr increments modulo DEPTH and count decrements.
- outN_valid = (countN != 0). outN_data = storage[rd_ptrN], registered storage with combinational read of the head.
- Latency: a beat pushed at edge k is visible on outN_valid/outN_data after edge k, i.e. one cycle. There is no same-cycle pass-through.
- Order: beats to the same output leave in arrival order. There is no ordering relation between out0 and out1.
- Simultaneous push and pop on the same FIFO:
  - pointers both advance and count is unchanged.
  - allowed at any count below DEPTH.
  - when full, the push is refused (in_ready = 0) even if a pop occurs that cycle.
- Full: countN == DEPTH. Further beats for N stall; the upstream must hold in_valid/in_sel/in_data stable until accepted.
- Empty: countN == 0. outN_valid = 0, and outN_ready is ignored with no pointer movement.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately so full and empty are unambiguous.
- A pop on one FIFO and a push to the other in the same cycle are independent.
- Reset mid-operation: all buffered beats are discarded immediately. No outN_valid is asserted until a new push.
- in_sel is sampled only together with in_valid; X on in_sel while in_valid = 0 must not propagate to state.

Decomposition:
- Shared package (cpu_pkg): WIDTH default, the ptr-width helper ($clog2) and the select encodings SEL_IF = 1'b0, SEL_MEM = 1'b1.
- One natural sub-module, demux_fifo (WIDTH, DEPTH), holding storage, pointers and count, with push/pop/full/empty/count/head ports. It is instantiated twice.
- The top level holds only the in_ready select and push-enable decode.

Test Plan:
- Reset then idle:
  - rst pulse mid-cycle, asynchronously → outN_valid = 0, outN_count = 0, outN_data = 0 immediately.
  - in_ready = 1 for both in_sel values.
- Routing:
  - push 0xA0 (sel 0), 0xB1 (sel 1), 0xA2 (sel 0), with out0_ready = out1_ready = 1 → out0 yields 0xA0 then 0xA2.
  - out1 yields 0xB1, each one cycle after its push.
- Fill and stall:
  - out0_ready = 0, push 0x11 and 0x22 to sel 0 → out0_count = 2 and in_ready = 0 for sel 0 while still 1 for sel 1.
  - pushing 0x33 to sel 1 succeeds.
- Full with simultaneous pop:
  - out0 full, out0_ready = 1, in_valid with sel 0 → no accept that cycle and 0x11 pops.
  - next cycle the push is accepted: count goes 2 → 1 → 2, and order 0x22 then 0x33' holds.
- Wrap-around: continuous push/pop of 0..9 on out1 with out1_ready = 1 → output 0..9 in order and count stays at or below 1.
- Reset mid-operation: both FIFOs hold 2 entries, assert rst → counts 0 and valids 0; after release, a new push of 0x55 appears alone on its output.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the response demultiplexer slice.
//   WIDTH_DEF : default payload width
//   sel_e     : beat destination encoding (SEL_IF -> out0, SEL_MEM -> out1)
//   ptr_w()   : FIFO pointer width for a given depth
package cpu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic {
    SEL_IF  = 1'b0,
    SEL_MEM = 1'b1
  } sel_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used per demux output.
//   clk, rst : clock, async active-high reset (clears storage too)
//   i_push   : write i_data (ignored when full)
//   i_pop    : drop head entry (ignored when empty)
//   o_full   : count == DEPTH
//   o_empty  : count == 0
//   o_count  : occupancy
//   o_head   : storage at read pointer (combinational read)
module demux_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = ptr_w(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      // Count tracked separately from pointers so full/empty never alias.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/resp_demux.sv
// 1-to-2 response demultiplexer with a FIFO per output.
//   clk, rst               : clock, async active-high reset
//   in_valid/in_sel/in_data/in_ready : input stream; in_sel 0 -> out0, 1 -> out1
//   out0_valid/out0_data/out0_ready  : instruction-fetch side stream
//   out1_valid/out1_data/out1_ready  : data side stream
//   out0_count/out1_count            : FIFO occupancy
// in_ready depends only on in_sel and registered state; no ready path
// passes combinationally from the outputs to the input.
module resp_demux
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);

  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_push0;
  logic w_push1;

  assign in_ready = (in_sel == SEL_MEM) ? !w_full1 : !w_full0;

  // in_valid gates first so an unknown in_sel while idle cannot reach state.
  assign w_push0 = in_valid && (in_sel == SEL_IF)  && !w_full0;
  assign w_push1 = in_valid && (in_sel == SEL_MEM) && !w_full1;

  assign out0_valid = !w_empty0;
  assign out1_valid = !w_empty1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push0),
    .i_data  (in_data),
    .i_pop   (out0_ready),
    .o_full  (w_full0),
    .o_empty (w_empty0),
    .o_count (out0_count),
    .o_head  (out0_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push1),
    .i_data  (in_data),
    .i_pop   (out1_ready),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_count (out1_count),
    .o_head  (out1_data)
  );

endmodule

// File: tb/tb_resp_demux.sv
module tb_resp_demux;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
  logic [CW-1:0]    out0_count;
  logic [CW-1:0]    out1_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  bit               last_acc;

  always #5 clk = ~clk;

  resp_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  // Advance one clock, updating the queue model from the spec's handshake rules;
  // returns at posedge+1.
  task automatic tick();
    bit acc, p0, p1;
    acc = in_valid && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
    p0  = out0_ready && (q0.size() > 0);
    p1  = out1_ready && (q1.size() > 0);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic test_reset();
    n_tests++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_v0: got %b want 0", out0_valid); end
    n_tests++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_v1: got %b want 0", out1_valid); end
    n_tests++; if (out0_count !== '0)   begin n_fail++; $display("FAIL rst_c0: got %0d want 0", out0_count); end
    n_tests++; if (out1_count !== '0)   begin n_fail++; $display("FAIL rst_c1: got %0d want 0", out1_count); end
    n_tests++; if (out0_data !== '0)    begin n_fail++; $display("FAIL rst_d0: got %h want 0", out0_data); end
    n_tests++; if (out1_data !== '0)    begin n_fail++; $display("FAIL rst_d1: got %h want 0", out1_data); end
    drive(0, 0, '0); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_rdy_sel0: got %b want 1", in_ready); end
    in_sel = 1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_rdy_sel1: got %b want 1", in_ready); end
    // Put a beat in each FIFO, then pulse reset between clock edges.
    out0_ready = 0; out1_ready = 0;
    drive(1, 0, 32'hDEAD0000); tick();
    drive(1, 1, 32'hDEAD0001); tick();
    drive(0, 0, '0);
    n_tests++; if (out0_count !== CW'(1)) begin n_fail++; $display("FAIL pre_rst_c0: got %0d want 1", out0_count); end
    #3 rst = 1; #1;
    q0.delete(); q1.delete();
    n_tests++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_v: got %b%b want 00", out0_valid, out1_valid); end
    n_tests++; if (out0_count !== '0 || out1_count !== '0) begin n_fail++; $display("FAIL async_rst_c: got %0d/%0d want 0/0", out0_count, out1_count); end
    n_tests++; if (out0_data !== '0 || out1_data !== '0) begin n_fail++; $display("FAIL async_rst_d: got %h/%h want 0/0", out0_data, out1_data); end
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_routing();
    out0_ready = 1; out1_ready = 1;
    drive(1, 0, 32'hA0); tick();
    n_tests++; if (!(out0_valid === 1'b1 && out0_data === 32'hA0)) begin n_fail++; $display("FAIL route_a0: got v=%b d=%h want v=1 d=a0", out0_valid, out0_data); end
    n_tests++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL route_a0_v1: got %b want 0", out1_valid); end
    drive(1, 1, 32'hB1); tick();
    n_tests++; if (!(out1_valid === 1'b1 && out1_data === 32'hB1)) begin n_fail++; $display("FAIL route_b1: got v=%b d=%h want v=1 d=b1", out1_valid, out1_data); end
    n_tests++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL route_b1_v0: got %b want 0", out0_valid); end
    drive(1, 0, 32'hA2); tick();
    n_tests++; if (!(out0_valid === 1'b1 && out0_data === 32'hA2)) begin n_fail++; $display("FAIL route_a2: got v=%b d=%h want v=1 d=a2", out0_valid, out0_data); end
    n_tests++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL route_a2_v1: got %b want 0", out1_valid); end
    drive(0, 0, '0); tick();
    n_tests++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL route_drain: got %b want 0", out0_valid); end
  endtask

  task automatic test_fill_stall();
    out0_ready = 0; out1_ready = 1;
    drive(1, 0, 32'h11); tick();
    drive(1, 0, 32'h22); tick();
    n_tests++; if (out0_count !== CW'(2)) begin n_fail++; $display("FAIL fill_count: got %0d want 2", out0_count); end
    drive(1, 0, 32'h33); #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy_sel0: got %b want 0", in_ready); end
    in_sel = 1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy_sel1: got %b want 1", in_ready); end
    tick();
    n_tests++; if (!(out1_valid === 1'b1 && out1_data === 32'h33)) begin n_fail++; $display("FAIL other_push: got v=%b d=%h want v=1 d=33", out1_valid, out1_data); end
    drive(0, 0, '0); tick();
    n_tests++; if (out1_count !== '0) begin n_fail++; $display("FAIL other_drain: got %0d want 0", out1_count); end
  endtask

  task automatic test_full_pop();
    // out0 still holds 0x11, 0x22.
    out0_ready = 1;
    drive(1, 0, 32'h33); #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_rdy: got %b want 0", in_ready); end
    tick();
    n_tests++; if (!(out0_count === CW'(1) && out0_data === 32'h22)) begin n_fail++; $display("FAIL fullpop_1: got c=%0d d=%h want c=1 d=22", out0_count, out0_data); end
    out0_ready = 0; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_rdy2: got %b want 1", in_ready); end
    tick();
    n_tests++; if (!(out0_count === CW'(2) && out0_data === 32'h22)) begin n_fail++; $display("FAIL fullpop_2: got c=%0d d=%h want c=2 d=22", out0_count, out0_data); end
    drive(0, 0, '0); out0_ready = 1; tick();
    n_tests++; if (!(out0_count === CW'(1) && out0_data === 32'h33)) begin n_fail++; $display("FAIL fullpop_3: got c=%0d d=%h want c=1 d=33", out0_count, out0_data); end
    tick();
    n_tests++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", out0_valid); end
  endtask

  task automatic test_wrap();
    out1_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, WIDTH'(i)); tick();
      n_tests++;
      if (!(out1_valid === 1'b1 && out1_data === WIDTH'(i) && out1_count === CW'(1))) begin
        n_fail++; $display("FAIL wrap_%0d: got v=%b d=%h c=%0d want v=1 d=%h c=1", i, out1_valid, out1_data, out1_count, i);
      end
    end
    drive(0, 0, '0); tick();
    n_tests++; if (out1_count !== '0) begin n_fail++; $display("FAIL wrap_drain: got %0d want 0", out1_count); end
  endtask

  task automatic test_reset_mid();
    out0_ready = 0; out1_ready = 0;
    drive(1, 0, 32'h01); tick();
    drive(1, 1, 32'h02); tick();
    drive(1, 0, 32'h03); tick();
    drive(1, 1, 32'h04); tick();
    drive(0, 0, '0);
    n_tests++; if (out0_count !== CW'(2) || out1_count !== CW'(2)) begin n_fail++; $display("FAIL mid_fill: got %0d/%0d want 2/2", out0_count, out1_count); end
    #3 rst = 1; #1;
    q0.delete(); q1.delete();
    n_tests++; if (out0_count !== '0 || out1_count !== '0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got c=%0d/%0d v=%b%b want 0/0 00", out0_count, out1_count, out0_valid, out1_valid);
    end
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    drive(1, 1, 32'h55); tick();
    drive(0, 0, '0);
    n_tests++; if (!(out1_valid === 1'b1 && out1_data === 32'h55 && out1_count === CW'(1) && out0_valid === 1'b0)) begin
      n_fail++; $display("FAIL mid_new: got v1=%b d=%h c=%0d v0=%b want 1 55 1 0", out1_valid, out1_data, out1_count, out0_valid);
    end
    out1_ready = 1; tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        if (in_valid) in_sel = 1'($urandom);
        else          in_sel = ($urandom_range(0, 1) != 0) ? 1'bx : 1'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!$isunknown(in_sel)) begin
        exp_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy c%0d: got %b want %b", c, in_ready, exp_rdy); end
      end
      tick();
      n_tests++; if (out0_count !== CW'(q0.size())) begin n_fail++; $display("FAIL rnd_c0 c%0d: got %0d want %0d", c, out0_count, q0.size()); end
      n_tests++; if (out1_count !== CW'(q1.size())) begin n_fail++; $display("FAIL rnd_c1 c%0d: got %0d want %0d", c, out1_count, q1.size()); end
      n_tests++; if (out0_valid !== (q0.size() != 0)) begin n_fail++; $display("FAIL rnd_v0 c%0d: got %b want %b", c, out0_valid, q0.size() != 0); end
      n_tests++; if (out1_valid !== (q1.size() != 0)) begin n_fail++; $display("FAIL rnd_v1 c%0d: got %b want %b", c, out1_valid, q1.size() != 0); end
      if (q0.size() != 0) begin
        n_tests++; if (out0_data !== q0[0]) begin n_fail++; $display("FAIL rnd_d0 c%0d: got %h want %h", c, out0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        n_tests++; if (out1_data !== q1[0]) begin n_fail++; $display("FAIL rnd_d1 c%0d: got %h want %h", c, out1_data, q1[0]); end
      end
    end
    drive(0, 0, '0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sel = 0; in_data = '0;
    out0_ready = 0; out1_ready = 0; last_acc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    test_reset();
    test_routing();
    test_fill_stall();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
